oversample_cdr: RTL and testbench

//  Receive-side partner of the clock divider. Recovers bit timing from a serial stream

---
 rtl/oversample_cdr.sv | 157 +++++++++++++++
 tb/tb_oversample_cdr.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/oversample_cdr.sv
// ============================================================================
// Module   : oversample_cdr
// Brief    : Oversampling clock/data recovery with edge-quality lock tracking.
//            Optional bad-edge counter port enabled by defining CDR_ERRCNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module oversample_cdr #(
    parameter int OSR          = 4,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        data_in,
    output logic        data_out,
    output logic        bit_valid,
    output logic        clk_out,
    output logic        locked
`ifdef CDR_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int c_cnt_w  = $clog2(OSR);
    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_bad_w  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(OSR - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_half = c_cnt_w'(OSR / 2);
    localparam logic [c_good_w-1:0] c_good_last = c_good_w'(LOCK_COUNT - 1);
    localparam logic [c_bad_w-1:0]  c_bad_last  = c_bad_w'(UNLOCK_COUNT - 1);

    localparam logic [0:0] c_st_hunt   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic                r_s1, r_s2, r_s3;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_data, r_bv, r_clk;
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_good_w-1:0] r_good_cnt;
    logic [c_bad_w-1:0]  r_bad_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                w_edge, w_in_win, w_good, w_bad;
    logic                w_lock_hit, w_unlock_hit;

    assign w_edge   = r_s2 ^ r_s3;
    // Edges within one sample of the expected bit boundary count as good
    assign w_in_win = (r_cnt == c_cnt_last) || (r_cnt == '0) || (r_cnt == c_cnt_one);
    assign w_good   = w_edge & w_in_win;
    assign w_bad    = w_edge & ~w_in_win;

    assign w_lock_hit   = w_good && (r_good_cnt == c_good_last);
    assign w_unlock_hit = w_bad  && (r_bad_cnt  == c_bad_last);

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_edge)
            w_cnt_next = c_cnt_one;
        else if (r_cnt == c_cnt_last)
            w_cnt_next = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_cnt  <= '0;
            r_data <= 1'b0;
            r_bv   <= 1'b0;
            r_clk  <= 1'b0;
        end else begin
            r_s1   <= data_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_cnt  <= w_cnt_next;
            r_bv   <= (r_cnt == c_cnt_half);
            r_clk  <= (w_cnt_next >= c_cnt_half);
            if (r_cnt == c_cnt_half)
                r_data <= r_s2;
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst)
            r_state <= c_st_hunt;
        else
            r_state <= w_state_next;
    end

    // Lock FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_hunt:   if (w_lock_hit)   w_state_next = c_st_locked;
            c_st_locked: if (w_unlock_hit) w_state_next = c_st_hunt;
            default:     w_state_next = c_st_hunt;
        endcase
    end

    // Lock FSM: output logic
    always_comb begin
        locked = (r_state == c_st_locked);
    end

    // Run-length counters; they hold whenever no edge is seen
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (w_edge) begin
            if (r_state == c_st_hunt) begin
                if (w_in_win) begin
                    r_good_cnt <= r_good_cnt + 1'b1;
                    if (w_lock_hit)
                        r_bad_cnt <= '0;
                end else begin
                    r_good_cnt <= '0;
                end
            end else begin
                if (!w_in_win) begin
                    r_bad_cnt <= r_bad_cnt + 1'b1;
                    if (w_unlock_hit)
                        r_good_cnt <= '0;
                end else begin
                    r_bad_cnt <= '0;
                end
            end
        end
    end

`ifdef CDR_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_in) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_bad && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign err_count = r_err_cnt;
`endif

    assign data_out  = r_data;
    assign bit_valid = r_bv;
    assign clk_out   = r_clk;

endmodule

`default_nettype wire

// File: tb/tb_oversample_cdr.sv
// ============================================================================
// Module   : tb_oversample_cdr
// Brief    : Self-checking bench for oversample_cdr against a timestamp-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_oversample_cdr;

    localparam int OSR          = 4;
    localparam int LOCK_COUNT   = 8;
    localparam int UNLOCK_COUNT = 4;

    logic clk_in = 1'b0;
    logic rst;
    logic data_in;
    logic data_out, bit_valid, clk_out, locked;
`ifdef CDR_ERRCNT_EN
    logic [15:0] err_count;
`endif

    oversample_cdr #(
        .OSR          (OSR),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .bit_valid (bit_valid),
        .clk_out   (clk_out),
        .locked    (locked)
`ifdef CDR_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, n);
    endtask

    // Reference model: pin history indexed by clock number; phase is time since the
    // last edge (or reset release) modulo OSR.
    int n = 0;
    bit pin [0:16383];
    int rel = 0;
    int anchor = 0;
    bit m_locked = 0;
    int good_run = 0;
    int bad_run = 0;
    int m_err = 0;
    bit e_do = 0, e_bv = 0, e_clk = 0;
    logic lvl = 1'b0;

    function automatic bit pe(input int k);
        return (k >= rel && k >= 0) ? pin[k] : 1'b0;
    endfunction

    task automatic model_step(input logic d, input logic r);
        bit s2, s3, edge_seen, good;
        int ph;
        pin[n] = d;
        if (r) begin
            rel = n + 1; anchor = n + 1;
            m_locked = 0; good_run = 0; bad_run = 0; m_err = 0;
            e_do = 0; e_bv = 0; e_clk = 0;
        end else begin
            s2 = pe(n - 2);
            s3 = pe(n - 3);
            ph = (n - anchor) % OSR;
            edge_seen = (s2 != s3);
            e_bv = (ph == OSR / 2);
            if (e_bv) e_do = s2;
            if (edge_seen) begin
                good = (ph == OSR - 1) || (ph == 0) || (ph == 1);
                if (good) begin good_run++; bad_run = 0; end
                else begin bad_run++; good_run = 0; if (m_err < 65535) m_err++; end
                if (!m_locked && good_run >= LOCK_COUNT) m_locked = 1;
                else if (m_locked && bad_run >= UNLOCK_COUNT) m_locked = 0;
                anchor = n;
            end
            e_clk = (((n + 1 - anchor) % OSR) >= OSR / 2);
        end
    endtask

    task automatic step(input logic d, input logic r);
        data_in = d;
        rst = r;
        @(posedge clk_in);
        model_step(d, r);
        #1;
        check("bit_valid", {31'd0, bit_valid}, {31'd0, e_bv});
        check("data_out",  {31'd0, data_out},  {31'd0, e_do});
        check("clk_out",   {31'd0, clk_out},   {31'd0, e_clk});
        check("locked",    {31'd0, locked},    {31'd0, m_locked});
`ifdef CDR_ERRCNT_EN
        check("err_count", {16'd0, err_count}, m_err);
`endif
        n++;
        @(negedge clk_in);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(i[0], 1'b1);
        lvl = 1'b0;
    endtask

    task automatic send(input logic v, input int len);
        lvl = v;
        for (int i = 0; i < len; i++) step(v, 1'b0);
    endtask

    task automatic alt(input int nbits, input int len);
        for (int i = 0; i < nbits; i++) send(~lvl, len);
    endtask

    initial begin
        int strobes, zeros;
        rst = 1'b1;
        data_in = 1'b0;
        @(negedge clk_in);

        // Reset with toggling input
        do_reset(3);
        check("reset_locked", {31'd0, locked}, 32'd0);

        // Nominal rate: lock acquired
        alt(16, 4);
        check("lock_nominal", {31'd0, locked}, 32'd1);

        // Slow rate: every edge lands at phase 2
        do_reset(1);
        alt(100, 6);
        check("no_lock_slow", {31'd0, locked}, 32'd0);
`ifdef CDR_ERRCNT_EN
        check("err_100", {16'd0, err_count}, 32'd100);
`endif

        // Lock, then four consecutive bad edges
        do_reset(1);
        alt(12, 4);
        check("lock_before_bad", {31'd0, locked}, 32'd1);
        alt(5, 6);
        check("unlock_4_bad", {31'd0, locked}, 32'd0);

        // Relock, then three bad edges followed by a good one
        alt(12, 4);
        check("relock", {31'd0, locked}, 32'd1);
        alt(3, 6);
        alt(1, 5);
        alt(4, 4);
        check("keep_lock_3_bad", {31'd0, locked}, 32'd1);

        // Long run of zeros while locked
        if (lvl) send(1'b0, 4);
        strobes = 0; zeros = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (bit_valid) begin
                strobes++;
                if (!data_out) zeros++;
            end
        end
        check("hold_strobes", strobes, 32'd10);
        check("hold_zeros", zeros, 32'd10);
        check("hold_locked", {31'd0, locked}, 32'd1);

        // Single-cycle reset pulse while locked
        step(lvl, 1'b1);
        lvl = 1'b0;
        check("pulse_locked", {31'd0, locked}, 32'd0);
        check("pulse_bv", {31'd0, bit_valid}, 32'd0);
        alt(12, 4);
        check("relock_after_rst", {31'd0, locked}, 32'd1);

        // Random bit lengths and values
        for (int i = 0; i < 400; i++)
            send(1'($urandom_range(0, 1)), $urandom_range(3, 6));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
